// File: rtl/pmu_overflow.sv
// Overflow detector for the PMU counter bank: spots MSB 1->0 transitions, keeps sticky
// per-counter flags, drives a registered level interrupt and a saturating overflow total.
module pmu_overflow #(
  parameter int unsigned N_COUNTERS = 9,
  parameter int unsigned REG_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH  = 16,
  localparam int unsigned IdxW      = (N_COUNTERS > 1) ? $clog2(N_COUNTERS) : 1
) (
  input  logic                             clk_i,
  input  logic                             rstn_i,
  input  logic                             en_i,
  input  logic                             softrst_i,
  input  logic                             we_i,
  input  logic [N_COUNTERS*REG_WIDTH-1:0]  counters_i,
  input  logic [N_COUNTERS-1:0]            ie_i,
  input  logic [N_COUNTERS-1:0]            clr_i,
  output logic [N_COUNTERS-1:0]            flags_o,
  output logic                             intr_o,
  output logic [IdxW-1:0]                  first_idx_o,
  output logic [CNT_WIDTH-1:0]             ovf_cnt_o
);

  logic [N_COUNTERS-1:0] msb_now;
  logic [N_COUNTERS-1:0] msb_q, msb_d;
  logic [N_COUNTERS-1:0] flags_q, flags_d;
  logic [N_COUNTERS-1:0] wrap;
  logic [N_COUNTERS-1:0] flags_ie;
  logic                  intr_q, intr_d;
  logic                  detect;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CNT_WIDTH:0]    sum;

  // Only the MSB of each counter matters; fold the rest into a sink so lint stays quiet.
  logic unused_counter_bits;
  assign unused_counter_bits = ^counters_i;

  // Pick out the MSB of every counter.
  always_comb begin
    msb_now = '0;
    for (int unsigned i = 0; i < N_COUNTERS; i++) begin
      msb_now[i] = counters_i[i*REG_WIDTH + REG_WIDTH - 1];
    end
  end

  // A wrap is a 1->0 MSB transition seen while detection is live.
  assign detect = en_i & ~we_i & ~softrst_i;
  assign wrap   = {N_COUNTERS{detect}} & msb_q & ~msb_now;

  // Next-state: flags (set beats clear), interrupt, clamped total, MSB history.
  always_comb begin
    sum = {1'b0, cnt_q};
    for (int unsigned i = 0; i < N_COUNTERS; i++) begin
      sum = sum + {{CNT_WIDTH{1'b0}}, wrap[i]};
    end
    flags_d = '0;
    intr_d  = 1'b0;
    cnt_d   = '0;
    msb_d   = '0;
    if (!softrst_i) begin
      flags_d = wrap | (flags_q & ~clr_i);
      intr_d  = |(flags_d & ie_i);
      cnt_d   = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
      msb_d   = msb_now;
    end
  end

  // Lowest-index enabled flag; scanning downward lets the lowest hit win.
  always_comb begin
    flags_ie    = flags_q & ie_i;
    first_idx_o = '0;
    for (int i = int'(N_COUNTERS) - 1; i >= 0; i--) begin
      if (flags_ie[i]) first_idx_o = IdxW'(i);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      msb_q   <= '0;
      flags_q <= '0;
      intr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      msb_q   <= msb_d;
      flags_q <= flags_d;
      intr_q  <= intr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign flags_o   = flags_q;
  assign intr_o    = intr_q;
  assign ovf_cnt_o = cnt_q;

endmodule

// File: tb/tb_pmu_overflow.sv
// Self-checking bench for pmu_overflow: directed vector table, saturation and async-reset
// sequences, then randomized traffic against a value-level reference model.
module tb_pmu_overflow;

  localparam int N = 9;
  localparam int W = 32;

  logic           clk;
  logic           rstn;
  logic           en, we, sr;
  logic [N*W-1:0] cnt;
  logic [N-1:0]   ie, clr;
  logic [N-1:0]   flags;
  logic           intr;
  logic [3:0]     idx;
  logic [15:0]    ovf;

  int n_checks = 0;
  int n_errors = 0;

  pmu_overflow #(
    .N_COUNTERS(N),
    .REG_WIDTH (W),
    .CNT_WIDTH (16)
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .en_i       (en),
    .softrst_i  (sr),
    .we_i       (we),
    .counters_i (cnt),
    .ie_i       (ie),
    .clr_i      (clr),
    .flags_o    (flags),
    .intr_o     (intr),
    .first_idx_o(idx),
    .ovf_cnt_o  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic           en, we, sr;
    logic [N*W-1:0] cnt;
    logic [N-1:0]   ie, clr;
    logic [N-1:0]   e_flags;
    logic           e_intr;
    logic [3:0]     e_idx;
    logic [15:0]    e_ovf;
  } vec_t;

  vec_t tbl[21];

  // Reference model state: previous counter values, sticky flags, interrupt, total.
  logic [W-1:0] m_prev[N];
  logic [N-1:0] m_flags;
  logic         m_intr;
  int           m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N*W-1:0] mkc(int a, logic [W-1:0] va, int b, logic [W-1:0] vb);
    logic [N*W-1:0] r;
    r = '0;
    if (a >= 0) r[a*W +: W] = va;
    if (b >= 0) r[b*W +: W] = vb;
    return r;
  endfunction

  function automatic logic [N*W-1:0] fill(int k, logic [W-1:0] v);
    logic [N*W-1:0] r;
    r = '0;
    for (int i = 0; i < k; i++) r[i*W +: W] = v;
    return r;
  endfunction

  function automatic vec_t mkv(logic e, logic w, logic s, logic [N*W-1:0] c, logic [N-1:0] ie_v,
                               logic [N-1:0] clr_v, logic [N-1:0] ef, logic ei, logic [3:0] ex,
                               logic [15:0] eo);
    vec_t v;
    v.en = e; v.we = w; v.sr = s; v.cnt = c; v.ie = ie_v; v.clr = clr_v;
    v.e_flags = ef; v.e_intr = ei; v.e_idx = ex; v.e_ovf = eo;
    return v;
  endfunction

  task automatic step(input logic e, input logic w, input logic s, input logic [N*W-1:0] c,
                      input logic [N-1:0] ie_v, input logic [N-1:0] clr_v);
    en = e; we = w; sr = s; cnt = c; ie = ie_v; clr = clr_v;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_prev[i] = '0;
    m_flags = '0;
    m_intr  = 1'b0;
    m_cnt   = 0;
  endtask

  // Value-level model: a wrap is a counter moving from the upper half of its range to the
  // lower half between consecutive cycles while detection is allowed.
  task automatic model_step(input logic e, input logic w, input logic s, input logic [N*W-1:0] c,
                            input logic [N-1:0] ie_v, input logic [N-1:0] clr_v);
    int k;
    logic [W-1:0] cur;
    if (s) begin
      model_reset();
      return;
    end
    k = 0;
    for (int i = 0; i < N; i++) begin
      cur = c[i*W +: W];
      if (e && !w && m_prev[i] >= 32'h8000_0000 && cur < 32'h8000_0000) begin
        m_flags[i] = 1'b1;
        k++;
      end else if (clr_v[i]) begin
        m_flags[i] = 1'b0;
      end
      m_prev[i] = cur;
    end
    m_cnt  = (m_cnt + k > 65535) ? 65535 : m_cnt + k;
    m_intr = |(m_flags & ie_v);
  endtask

  function automatic logic [3:0] model_idx(logic [N-1:0] ie_v);
    for (int i = 0; i < N; i++) if (m_flags[i] && ie_v[i]) return 4'(i);
    return 4'd0;
  endfunction

  task automatic do_reset();
    rstn = 1'b0;
    en = 1'b0; we = 1'b0; sr = 1'b0; cnt = '0; ie = '0; clr = '0;
    @(posedge clk);
    #1;
    chk("reset_flags", 32'(flags), 32'h0);
    chk("reset_intr",  32'(intr),  32'h0);
    chk("reset_idx",   32'(idx),   32'h0);
    chk("reset_ovf",   32'(ovf),   32'h0);
    rstn = 1'b1;
    model_reset();
  endtask

  initial begin
    rstn = 1'b0;
    // Directed table, applied back to back from reset.
    tbl[0]  = mkv(1, 0, 0, mkc(-1, 0, -1, 0),               9'h000, 9'h000, 9'h000, 0, 0, 0);
    tbl[1]  = mkv(1, 0, 0, mkc(0, 32'hFFFF_FFFE, -1, 0),    9'h001, 9'h000, 9'h000, 0, 0, 0);
    tbl[2]  = mkv(1, 0, 0, mkc(0, 32'hFFFF_FFFF, -1, 0),    9'h001, 9'h000, 9'h000, 0, 0, 0);
    tbl[3]  = mkv(1, 0, 0, mkc(-1, 0, -1, 0),               9'h001, 9'h000, 9'h001, 1, 0, 1);
    tbl[4]  = mkv(1, 0, 0, mkc(-1, 0, -1, 0),               9'h001, 9'h001, 9'h000, 0, 0, 1);
    tbl[5]  = mkv(1, 0, 0, mkc(0, 32'hFFFF_FFFF, -1, 0),    9'h001, 9'h000, 9'h000, 0, 0, 1);
    tbl[6]  = mkv(1, 1, 0, mkc(-1, 0, -1, 0),               9'h001, 9'h000, 9'h000, 0, 0, 1);
    tbl[7]  = mkv(1, 0, 0, mkc(3, 32'h8000_0000, 7, 32'h8000_0000),
                                                            9'h080, 9'h000, 9'h000, 0, 0, 1);
    tbl[8]  = mkv(1, 0, 0, mkc(-1, 0, -1, 0),               9'h080, 9'h000, 9'h088, 1, 7, 3);
    tbl[9]  = mkv(1, 0, 0, mkc(-1, 0, -1, 0),               9'h080, 9'h080, 9'h008, 0, 0, 3);
    tbl[10] = mkv(1, 0, 0, mkc(2, 32'h8000_0000, -1, 0),    9'h000, 9'h000, 9'h008, 0, 0, 3);
    tbl[11] = mkv(1, 0, 0, mkc(-1, 0, -1, 0),               9'h000, 9'h004, 9'h00C, 0, 0, 4);
    tbl[12] = mkv(1, 0, 0, mkc(2, 32'h8000_0000, -1, 0),    9'h008, 9'h000, 9'h00C, 1, 3, 4);
    tbl[13] = mkv(1, 0, 1, mkc(2, 32'h8000_0000, -1, 0),    9'h008, 9'h000, 9'h000, 0, 0, 0);
    tbl[14] = mkv(1, 0, 0, mkc(-1, 0, -1, 0),               9'h008, 9'h000, 9'h000, 0, 0, 0);
    tbl[15] = mkv(1, 0, 0, mkc(5, 32'hFFFF_FFFF, -1, 0),    9'h1FF, 9'h000, 9'h000, 0, 0, 0);
    tbl[16] = mkv(0, 0, 0, mkc(-1, 0, -1, 0),               9'h1FF, 9'h000, 9'h000, 0, 0, 0);
    tbl[17] = mkv(1, 0, 0, mkc(5, 32'hFFFF_FFFF, -1, 0),    9'h1FF, 9'h000, 9'h000, 0, 0, 0);
    tbl[18] = mkv(1, 0, 0, mkc(-1, 0, -1, 0),               9'h1FF, 9'h000, 9'h020, 1, 5, 1);
    tbl[19] = mkv(0, 0, 0, mkc(5, 32'hFFFF_FFFF, -1, 0),    9'h1FF, 9'h020, 9'h000, 0, 0, 1);
    tbl[20] = mkv(0, 0, 0, mkc(-1, 0, -1, 0),               9'h1FF, 9'h000, 9'h000, 0, 0, 1);

    do_reset();
    for (int v = 0; v < 21; v++) begin
      step(tbl[v].en, tbl[v].we, tbl[v].sr, tbl[v].cnt, tbl[v].ie, tbl[v].clr);
      chk($sformatf("tbl%0d_flags", v), 32'(flags), 32'(tbl[v].e_flags));
      chk($sformatf("tbl%0d_intr", v),  32'(intr),  32'(tbl[v].e_intr));
      chk($sformatf("tbl%0d_idx", v),   32'(idx),   32'(tbl[v].e_idx));
      chk($sformatf("tbl%0d_ovf", v),   32'(ovf),   32'(tbl[v].e_ovf));
    end

    // Saturation: 7281 nine-way wraps plus one five-way wrap brings the total to 0xFFFE.
    do_reset();
    for (int r = 0; r < 7281; r++) begin
      step(1, 0, 0, fill(9, 32'h8000_0000), '0, '0);
      step(1, 0, 0, fill(9, 32'h0), '0, '0);
    end
    step(1, 0, 0, fill(5, 32'h8000_0000), '0, '0);
    step(1, 0, 0, fill(9, 32'h0), '0, '0);
    chk("sat_preload", 32'(ovf), 32'hFFFE);
    step(1, 0, 0, fill(3, 32'h8000_0000), '0, '0);
    step(1, 0, 0, fill(9, 32'h0), '0, '0);
    chk("sat_clamp", 32'(ovf), 32'hFFFF);
    step(1, 0, 0, fill(9, 32'h8000_0000), '0, '0);
    step(1, 0, 0, fill(9, 32'h0), '0, '0);
    chk("sat_hold", 32'(ovf), 32'hFFFF);
    chk("sat_flags", 32'(flags), 32'h1FF);

    // Asynchronous reset mid-cycle, well away from any clock edge.
    step(1, 0, 0, fill(9, 32'h0), 9'h1FF, '0);
    chk("pre_arst_intr", 32'(intr), 32'h1);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_flags", 32'(flags), 32'h0);
    chk("arst_intr",  32'(intr),  32'h0);
    chk("arst_idx",   32'(idx),   32'h0);
    chk("arst_ovf",   32'(ovf),   32'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic           r_en, r_we, r_sr;
      logic [N*W-1:0] r_cnt;
      logic [N-1:0]   r_ie, r_clr;
      r_en  = ($urandom_range(0, 9) != 0);
      r_we  = ($urandom_range(0, 7) == 0);
      r_sr  = ($urandom_range(0, 99) == 0);
      r_ie  = 9'($urandom);
      r_clr = 9'($urandom & $urandom & $urandom);
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 4))
          0:       r_cnt[i*W +: W] = 32'h0000_0000;
          1:       r_cnt[i*W +: W] = 32'h7FFF_FFFF;
          2:       r_cnt[i*W +: W] = 32'h8000_0000;
          3:       r_cnt[i*W +: W] = 32'hFFFF_FFFF;
          default: r_cnt[i*W +: W] = $urandom;
        endcase
      end
      step(r_en, r_we, r_sr, r_cnt, r_ie, r_clr);
      model_step(r_en, r_we, r_sr, r_cnt, r_ie, r_clr);
      chk("rnd_flags", 32'(flags), 32'(m_flags));
      chk("rnd_intr",  32'(intr),  32'(m_intr));
      chk("rnd_idx",   32'(idx),   32'(model_idx(r_ie)));
      chk("rnd_ovf",   32'(ovf),   32'(m_cnt));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
